// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared constants and types for the multi-cycle control sequencer:
// opcode values, state encodings, ALU / source-select codes, trap causes
// and the bundle of datapath control strobes.
package multi_cycle_ctrl_pkg;

   // Opcodes (instr[6:0])
   localparam logic [6:0] OP_R_TYPE = 7'b0110011;
   localparam logic [6:0] OP_I_TYPE = 7'b0010011;
   localparam logic [6:0] OP_L_TYPE = 7'b0000011;
   localparam logic [6:0] OP_S_TYPE = 7'b0100011;
   localparam logic [6:0] OP_B_TYPE = 7'b1100011;

   // State encodings, also visible on state_dbg
   localparam logic [3:0] MC_S_RESET    = 4'd0;
   localparam logic [3:0] MC_S_FETCH    = 4'd1;
   localparam logic [3:0] MC_S_DECODE   = 4'd2;
   localparam logic [3:0] MC_S_EXEC_R   = 4'd3;
   localparam logic [3:0] MC_S_EXEC_I   = 4'd4;
   localparam logic [3:0] MC_S_MEM_ADDR = 4'd5;
   localparam logic [3:0] MC_S_MEM_RD   = 4'd6;
   localparam logic [3:0] MC_S_MEM_WR   = 4'd7;
   localparam logic [3:0] MC_S_WB_ALU   = 4'd8;
   localparam logic [3:0] MC_S_WB_MEM   = 4'd9;
   localparam logic [3:0] MC_S_BRANCH   = 4'd10;
   localparam logic [3:0] MC_S_TRAP     = 4'd15;

   // ALU operation select
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   // ALU operand B select
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;

   // Trap causes
   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

   typedef enum logic [3:0] {
      ST_RESET    = MC_S_RESET,
      ST_FETCH    = MC_S_FETCH,
      ST_DECODE   = MC_S_DECODE,
      ST_EXEC_R   = MC_S_EXEC_R,
      ST_EXEC_I   = MC_S_EXEC_I,
      ST_MEM_ADDR = MC_S_MEM_ADDR,
      ST_MEM_RD   = MC_S_MEM_RD,
      ST_MEM_WR   = MC_S_MEM_WR,
      ST_WB_ALU   = MC_S_WB_ALU,
      ST_WB_MEM   = MC_S_WB_MEM,
      ST_BRANCH   = MC_S_BRANCH,
      ST_TRAP     = MC_S_TRAP
   } state_t;

   // Every datapath strobe the sequencer drives, zero means idle
   typedef struct packed {
      logic       pc_write;
      logic       pc_src;
      logic       ir_write;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       retired;
   } ctrl_t;

   // States that hold a memory request open and may have to wait
   function automatic logic is_wait_state(input state_t s);
      return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
   endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter with timeout compare. Counts cycles spent waiting
// on mem_ready and flags expiry on the waiting cycle that reaches
// MEM_TIMEOUT, unless memory answers in that same cycle.
module mc_wait_timer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic waiting,
   input  logic ready,
   output logic expired
);

   localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);

   logic [7:0] cnt;

   // Wait-cycle count: restarts outside wait states and on every handshake
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      if (rst) begin
         cnt <= '0;
      end else if (clr || ready) begin
         cnt <= '0;
      end else if (waiting) begin
         cnt <= cnt + 8'd1;
      end
   end

   // cnt holds the number of earlier wait cycles, so this cycle is the
   // MEM_TIMEOUT-th one when cnt has reached MEM_TIMEOUT-1
   assign expired = waiting && !ready && (cnt >= LIMIT);

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control sequencer for the shared RISC-V datapath: steps
// fetch / decode / execute / memory / writeback, waits on the memory
// handshake and traps on illegal opcodes or memory timeout.
// Optional build macro MC_PERF_CNT_EN adds cycle_cnt and instret_cnt.
module multi_cycle_ctrl
   import multi_cycle_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
`ifdef MC_PERF_CNT_EN
   , parameter int CNT_W = 32
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opcode,
   input  logic             cond,
   input  logic             mem_ready,
   output logic             pcWrite,
   output logic             pcSrc,
   output logic             irWrite,
   output logic             iorD,
   output logic             memRead,
   output logic             memWrite,
   output logic             memToReg,
   output logic             regWrite,
   output logic             aluSrcA,
   output logic [1:0]       aluSrcB,
   output logic [1:0]       aluOp,
   output logic             retired,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic [3:0]       state_dbg
`ifdef MC_PERF_CNT_EN
   , output logic [CNT_W-1:0] cycle_cnt
   , output logic [CNT_W-1:0] instret_cnt
`endif
);

   state_t     state;
   state_t     state_nxt;
   ctrl_t      ctrl;
   logic [1:0] cause_nxt;
   logic       waiting;
   logic       expired;

   assign waiting = is_wait_state(state);

   mc_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (!waiting),
      .waiting (waiting),
      .ready   (mem_ready),
      .expired (expired)
   );

   // State register; reset aborts any instruction in flight immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_RESET;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and control strobe decode
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a value unassigned and infers a latch.
      state_nxt = state;
      cause_nxt = CAUSE_NONE;
      ctrl      = '0;
      case (state)
         ST_RESET: begin
            state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            ctrl.iord      = 1'b0;
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_a = 1'b0;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALU_ADD;
            if (mem_ready) begin
               ctrl.ir_write = 1'b1;
               ctrl.pc_write = 1'b1;
               ctrl.pc_src   = 1'b0;
               state_nxt     = ST_DECODE;
            end else if (expired) begin
               state_nxt = ST_TRAP;
               cause_nxt = CAUSE_TIMEOUT;
            end
         end
         ST_DECODE: begin
            // Precompute the branch target into ALUOut while dispatching
            ctrl.alu_src_a = 1'b0;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALU_ADD;
            case (opcode)
               OP_R_TYPE: state_nxt = ST_EXEC_R;
               OP_I_TYPE: state_nxt = ST_EXEC_I;
               OP_L_TYPE: state_nxt = ST_MEM_ADDR;
               OP_S_TYPE: state_nxt = ST_MEM_ADDR;
               OP_B_TYPE: state_nxt = ST_BRANCH;
               default: begin
                  state_nxt = ST_TRAP;
                  cause_nxt = CAUSE_ILLEGAL;
               end
            endcase
         end
         ST_EXEC_R: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_RS2;
            ctrl.alu_op    = ALU_FUNCT;
            state_nxt      = ST_WB_ALU;
         end
         ST_EXEC_I: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALU_FUNCT;
            state_nxt      = ST_WB_ALU;
         end
         ST_MEM_ADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALU_ADD;
            // DECODE only lets loads and stores reach this state
            state_nxt      = (opcode == OP_L_TYPE) ? ST_MEM_RD : ST_MEM_WR;
         end
         ST_MEM_RD: begin
            ctrl.iord     = 1'b1;
            ctrl.mem_read = 1'b1;
            if (mem_ready) begin
               state_nxt = ST_WB_MEM;
            end else if (expired) begin
               state_nxt = ST_TRAP;
               cause_nxt = CAUSE_TIMEOUT;
            end
         end
         ST_MEM_WR: begin
            ctrl.iord      = 1'b1;
            ctrl.mem_write = 1'b1;
            if (mem_ready) begin
               ctrl.retired = 1'b1;
               state_nxt    = ST_FETCH;
            end else if (expired) begin
               state_nxt = ST_TRAP;
               cause_nxt = CAUSE_TIMEOUT;
            end
         end
         ST_WB_ALU: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b0;
            ctrl.retired    = 1'b1;
            state_nxt       = ST_FETCH;
         end
         ST_WB_MEM: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.retired    = 1'b1;
            state_nxt       = ST_FETCH;
         end
         ST_BRANCH: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_RS2;
            ctrl.alu_op    = ALU_SUB;
            ctrl.pc_src    = 1'b1;
            ctrl.pc_write  = cond;
            ctrl.retired   = 1'b1;
            state_nxt      = ST_FETCH;
         end
         ST_TRAP: begin
            // Parked with every strobe idle until reset
            state_nxt = ST_TRAP;
         end
         default: begin
            state_nxt = ST_RESET;
         end
      endcase
   end

   // Sticky trap flag; only the transition into TRAP records a cause, so
   // the first cause is the one kept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trap       <= 1'b0;
         trap_cause <= CAUSE_NONE;
      end else if ((state != ST_TRAP) && (state_nxt == ST_TRAP)) begin
         trap       <= 1'b1;
         trap_cause <= cause_nxt;
      end
   end

`ifdef MC_PERF_CNT_EN
   // Performance counters: active cycles and retired instructions
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         if ((state != ST_RESET) && (state != ST_TRAP)) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
         end
         if (ctrl.retired) begin
            instret_cnt <= instret_cnt + CNT_W'(1);
         end
      end
   end
`endif

   assign pcWrite   = ctrl.pc_write;
   assign pcSrc     = ctrl.pc_src;
   assign irWrite   = ctrl.ir_write;
   assign iorD      = ctrl.iord;
   assign memRead   = ctrl.mem_read;
   assign memWrite  = ctrl.mem_write;
   assign memToReg  = ctrl.mem_to_reg;
   assign regWrite  = ctrl.reg_write;
   assign aluSrcA   = ctrl.alu_src_a;
   assign aluSrcB   = ctrl.alu_src_b;
   assign aluOp     = ctrl.alu_op;
   assign retired   = ctrl.retired;
   assign state_dbg = state;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: a directed vector table, hand
// sequences for memory waits, traps, timeout edges and reset mid-access,
// then random instruction streams against a per-instruction phase model.
module tb_multi_cycle_ctrl;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_L  = 7'b0000011;
   localparam logic [6:0] OP_S  = 7'b0100011;
   localparam logic [6:0] OP_B  = 7'b1100011;
   localparam logic [6:0] OP_BAD = 7'b1111111;

   // Expected strobes, packed as
   // {pcWrite,pcSrc,irWrite,iorD,memRead,memWrite,memToReg,regWrite,aluSrcA,aluSrcB,aluOp,retired}
   localparam logic [13:0] O_ZERO        = 14'd0;
   localparam logic [13:0] O_FETCH_WAIT  = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b0};
   localparam logic [13:0] O_FETCH_DONE  = {1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b0};
   localparam logic [13:0] O_DECODE      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,1'b0};
   localparam logic [13:0] O_EXEC_R      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,1'b0};
   localparam logic [13:0] O_EXEC_I      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b10,1'b0};
   localparam logic [13:0] O_MEM_ADDR    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,1'b0};
   localparam logic [13:0] O_MEM_RD      = {1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0};
   localparam logic [13:0] O_MEM_WR_WAIT = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0};
   localparam logic [13:0] O_MEM_WR_DONE = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1};
   localparam logic [13:0] O_WB_ALU      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,1'b1};
   localparam logic [13:0] O_WB_MEM      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,1'b1};
   localparam logic [13:0] O_BR_T        = {1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,1'b1};
   localparam logic [13:0] O_BR_N        = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,1'b1};

   localparam int TIMEOUT = 15;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] opcode = 7'd0;
   logic       cond = 1'b0;
   logic       mem_ready = 1'b0;
   logic       pcWrite, pcSrc, irWrite, iorD, memRead, memWrite, memToReg, regWrite;
   logic       aluSrcA, retired, trap;
   logic [1:0] aluSrcB, aluOp, trap_cause;
   logic [3:0] state_dbg;
`ifdef MC_PERF_CNT_EN
   logic [31:0] cycle_cnt, instret_cnt;
`endif

   logic [13:0] dut_o;
   assign dut_o = {pcWrite, pcSrc, irWrite, iorD, memRead, memWrite, memToReg,
                   regWrite, aluSrcA, aluSrcB, aluOp, retired};

   multi_cycle_ctrl #(
      .MEM_TIMEOUT (TIMEOUT)
`ifdef MC_PERF_CNT_EN
      , .CNT_W     (32)
`endif
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .cond       (cond),
      .mem_ready  (mem_ready),
      .pcWrite    (pcWrite),
      .pcSrc      (pcSrc),
      .irWrite    (irWrite),
      .iorD       (iorD),
      .memRead    (memRead),
      .memWrite   (memWrite),
      .memToReg   (memToReg),
      .regWrite   (regWrite),
      .aluSrcA    (aluSrcA),
      .aluSrcB    (aluSrcB),
      .aluOp      (aluOp),
      .retired    (retired),
      .trap       (trap),
      .trap_cause (trap_cause),
      .state_dbg  (state_dbg)
`ifdef MC_PERF_CNT_EN
      , .cycle_cnt   (cycle_cnt)
      , .instret_cnt (instret_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model bookkeeping: expected trap cause and counter values
   logic [1:0] m_cause = 2'b00;
   int         m_cyc   = 0;
   int         m_ret   = 0;

   typedef struct {
      logic        ready;
      logic        cond;
      logic [3:0]  st;
      logic [13:0] o;
   } cyc_t;

   typedef struct {
      logic [6:0]  op;
      logic        ready;
      logic        cond;
      logic [3:0]  st;
      logic [13:0] o;
   } vec_t;

   cyc_t cq[$];
   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // One clock cycle: drive at the falling edge, sample 1 time unit later,
   // i.e. well before the rising edge that consumes the inputs
   task automatic run_cycle(input logic [6:0] op, input logic rdy, input logic cnd,
                            input logic [3:0] st, input logic [13:0] o);
      @(negedge clk);
      opcode    = op;
      mem_ready = rdy;
      cond      = cnd;
      #1;
      check("state_dbg", 32'(state_dbg), 32'(st));
      check("ctrl", 32'(dut_o), 32'(o));
      check("trap", 32'({trap, trap_cause}), 32'({(st == 4'd15), m_cause}));
`ifdef MC_PERF_CNT_EN
      check("cycle_cnt", cycle_cnt, 32'(m_cyc));
      check("instret_cnt", instret_cnt, 32'(m_ret));
`endif
      if (st != 4'd0 && st != 4'd15) m_cyc++;
      if (o[0]) m_ret++;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      mem_ready = 1'b1;
      cond      = 1'b1;
      opcode    = OP_R;
      m_cyc     = 0;
      m_ret     = 0;
      m_cause   = 2'b00;
      repeat (2) @(negedge clk);
      #1;
      check("rst_state", 32'(state_dbg), 32'd0);
      check("rst_ctrl", 32'(dut_o), 32'd0);
      check("rst_trap", 32'({trap, trap_cause}), 32'd0);
`ifdef MC_PERF_CNT_EN
      check("rst_cycle_cnt", cycle_cnt, 32'd0);
      check("rst_instret_cnt", instret_cnt, 32'd0);
`endif
      rst = 1'b0;
      // The rest of this cycle is the single RESET-state cycle
   endtask

   task automatic push(input logic r, input logic c, input logic [3:0] s, input logic [13:0] o);
      cq.push_back('{r, c, s, o});
   endtask

   // Phase script of one instruction: fw fetch waits, mw memory waits.
   // kind: 0 R, 1 I, 2 load, 3 store, 4 branch taken, 5 branch not taken
   task automatic model_instr(input int kind, input int fw, input int mw);
      for (int i = 0; i < fw; i++) push(1'b0, rb(), 4'd1, O_FETCH_WAIT);
      push(1'b1, rb(), 4'd1, O_FETCH_DONE);
      push(rb(), rb(), 4'd2, O_DECODE);
      case (kind)
         0: begin push(rb(), rb(), 4'd3, O_EXEC_R); push(rb(), rb(), 4'd8, O_WB_ALU); end
         1: begin push(rb(), rb(), 4'd4, O_EXEC_I); push(rb(), rb(), 4'd8, O_WB_ALU); end
         2: begin
            push(rb(), rb(), 4'd5, O_MEM_ADDR);
            for (int i = 0; i < mw; i++) push(1'b0, rb(), 4'd6, O_MEM_RD);
            push(1'b1, rb(), 4'd6, O_MEM_RD);
            push(rb(), rb(), 4'd9, O_WB_MEM);
         end
         3: begin
            push(rb(), rb(), 4'd5, O_MEM_ADDR);
            for (int i = 0; i < mw; i++) push(1'b0, rb(), 4'd7, O_MEM_WR_WAIT);
            push(1'b1, rb(), 4'd7, O_MEM_WR_DONE);
         end
         4: push(rb(), 1'b1, 4'd10, O_BR_T);
         default: push(rb(), 1'b0, 4'd10, O_BR_N);
      endcase
   endtask

   task automatic run_q(input logic [6:0] op);
      while (cq.size() > 0) begin
         cyc_t c = cq.pop_front();
         run_cycle(op, c.ready, c.cond, c.st, c.o);
      end
   endtask

   function automatic logic [6:0] op_of(input int kind);
      case (kind)
         0: return OP_R;
         1: return OP_I;
         2: return OP_L;
         3: return OP_S;
         default: return OP_B;
      endcase
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Back-to-back R, taken branch, not-taken branch, I with zero wait
      vecs[0]  = '{OP_R, 1'b1, 1'b0, 4'd1,  O_FETCH_DONE};
      vecs[1]  = '{OP_R, 1'b1, 1'b0, 4'd2,  O_DECODE};
      vecs[2]  = '{OP_R, 1'b1, 1'b0, 4'd3,  O_EXEC_R};
      vecs[3]  = '{OP_R, 1'b1, 1'b0, 4'd8,  O_WB_ALU};
      vecs[4]  = '{OP_B, 1'b1, 1'b1, 4'd1,  O_FETCH_DONE};
      vecs[5]  = '{OP_B, 1'b1, 1'b1, 4'd2,  O_DECODE};
      vecs[6]  = '{OP_B, 1'b1, 1'b1, 4'd10, O_BR_T};
      vecs[7]  = '{OP_B, 1'b1, 1'b0, 4'd1,  O_FETCH_DONE};
      vecs[8]  = '{OP_B, 1'b1, 1'b0, 4'd2,  O_DECODE};
      vecs[9]  = '{OP_B, 1'b1, 1'b0, 4'd10, O_BR_N};
      vecs[10] = '{OP_I, 1'b1, 1'b0, 4'd1,  O_FETCH_DONE};
      vecs[11] = '{OP_I, 1'b1, 1'b0, 4'd2,  O_DECODE};
      vecs[12] = '{OP_I, 1'b1, 1'b0, 4'd4,  O_EXEC_I};
      vecs[13] = '{OP_I, 1'b1, 1'b0, 4'd8,  O_WB_ALU};

      do_reset();
      for (int i = 0; i < 14; i++)
         run_cycle(vecs[i].op, vecs[i].ready, vecs[i].cond, vecs[i].st, vecs[i].o);

      // Load with three wait cycles in MEM_RD, retires at cycle 8
      do_reset();
      model_instr(2, 0, 3);
      run_q(OP_L);

      // Illegal opcode: TRAP after DECODE, idle strobes for 20 cycles
      do_reset();
      run_cycle(OP_BAD, 1'b1, 1'b0, 4'd1, O_FETCH_DONE);
      run_cycle(OP_BAD, 1'b1, 1'b0, 4'd2, O_DECODE);
      m_cause = 2'b01;
      for (int i = 0; i < 20; i++) run_cycle(OP_BAD, rb(), rb(), 4'd15, O_ZERO);

      // Fetch timeout: 15 wait cycles then TRAP with cause 10
      do_reset();
      for (int i = 0; i < TIMEOUT; i++) run_cycle(OP_R, 1'b0, rb(), 4'd1, O_FETCH_WAIT);
      m_cause = 2'b10;
      for (int i = 0; i < 5; i++) run_cycle(OP_R, rb(), rb(), 4'd15, O_ZERO);

      // mem_ready on the 15th wait cycle wins over the timeout
      do_reset();
      for (int i = 0; i < TIMEOUT - 1; i++) run_cycle(OP_R, 1'b0, rb(), 4'd1, O_FETCH_WAIT);
      run_cycle(OP_R, 1'b1, 1'b0, 4'd1, O_FETCH_DONE);
      run_cycle(OP_R, 1'b0, 1'b0, 4'd2, O_DECODE);
      run_cycle(OP_R, 1'b0, 1'b0, 4'd3, O_EXEC_R);
      run_cycle(OP_R, 1'b0, 1'b0, 4'd8, O_WB_ALU);

      // Two R and one store with zero wait, then sample counters
      do_reset();
      model_instr(0, 0, 0); run_q(OP_R);
      model_instr(0, 0, 0); run_q(OP_R);
      model_instr(3, 0, 0); run_q(OP_S);
      run_cycle(OP_S, 1'b0, 1'b0, 4'd1, O_FETCH_WAIT);
      run_cycle(OP_S, 1'b0, 1'b0, 4'd1, O_FETCH_WAIT);
`ifdef MC_PERF_CNT_EN
      check("perf_cycle_cnt", cycle_cnt, 32'd13);
      check("perf_instret_cnt", instret_cnt, 32'd3);
`endif

      // Reset asserted while a store is waiting in MEM_WR
      run_cycle(OP_S, 1'b1, 1'b0, 4'd1, O_FETCH_DONE);
      run_cycle(OP_S, 1'b0, 1'b0, 4'd2, O_DECODE);
      run_cycle(OP_S, 1'b0, 1'b0, 4'd5, O_MEM_ADDR);
      run_cycle(OP_S, 1'b0, 1'b0, 4'd7, O_MEM_WR_WAIT);
      mem_ready = 1'b1;
      #1;
      check("memwr_ready", 32'(dut_o), 32'(O_MEM_WR_DONE));
      rst = 1'b1;
      #1;
      check("abort_memwrite", 32'(memWrite), 32'd0);
      check("abort_ctrl", 32'(dut_o), 32'd0);
      check("abort_state", 32'(state_dbg), 32'd0);
`ifdef MC_PERF_CNT_EN
      check("abort_cycle_cnt", cycle_cnt, 32'd0);
      check("abort_instret_cnt", instret_cnt, 32'd0);
`endif

      // Random instruction stream with waits up to one below the timeout
      do_reset();
      for (int n = 0; n < 40; n++) begin
         int kind;
         kind = int'($urandom_range(0, 5));
         model_instr(kind, int'($urandom_range(0, TIMEOUT - 1)), int'($urandom_range(0, TIMEOUT - 1)));
         run_q(op_of(kind));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
